// File: rtl/mod_counter_chain_pkg.sv
// Shared types and helpers for the cascaded wall-clock counter.
package mod_counter_chain_pkg;

    localparam int MAX_STAGES = 8;
    localparam int MAX_WIDTH  = 16;
    localparam int MOD_BITS   = MAX_STAGES * MAX_WIDTH;

    typedef logic [2:0] stage_idx_t;

    // Extract the width-bit modulus of stage i from a packed modulus vector.
    function automatic logic [MAX_WIDTH-1:0] mod_of(
        input logic [MOD_BITS-1:0] moduli,
        input int                  width,
        input int                  i
    );
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int b = 0; b < MAX_WIDTH; b++) begin
            if (b < width) r[b] = moduli[i*width+b];
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_stage_counter.sv
// One modulo stage: clear, load, step up/down with wrap, square-wave flag.
module mod_stage_counter
    import mod_counter_chain_pkg::*;
#(
    parameter int               WIDTH = 6,
    parameter logic [WIDTH-1:0] MAX_V = '1
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             step,
    input  logic             up_down,
    output logic [WIDTH-1:0] value,
    output logic             at_term,
    output logic             sq
);

    localparam logic [WIDTH-1:0] HALF = MAX_V >> 1;

    logic [WIDTH-1:0] nextValue;

    always_comb begin
        nextValue = value;
        if (clr) begin
            nextValue = '0;
        end else if (load) begin
            nextValue = load_value;
        end else if (step) begin
            if (up_down)
                nextValue = (value == MAX_V) ? '0 : value + WIDTH'(1);
            else
                nextValue = (value == '0) ? MAX_V : value - WIDTH'(1);
        end
    end

    assign at_term = up_down ? (value == MAX_V) : (value == '0);

    // sq is registered from the next value so it stays coincident with value.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            value <= '0;
            sq    <= 1'b0;
        end else begin
            value <= nextValue;
            sq    <= (nextValue > HALF);
        end
    end

endmodule

// File: rtl/mod_counter_chain.sv
// Cascaded modulo counter chain with time-set load and chain carry.
module mod_counter_chain
    import mod_counter_chain_pkg::*;
#(
    parameter int                              NUM_STAGES = 3,
    parameter int                              WIDTH      = 6,
    parameter logic [NUM_STAGES*WIDTH-1:0]     MODULI     = {6'd24, 6'd60, 6'd60}
) (
    input  logic                        clk,
    input  logic                        nReset,
    input  logic                        clr,
    input  logic                        tick_en,
    input  logic                        up_down,
    input  logic                        load_valid,
    input  stage_idx_t                  load_stage,
    input  logic [WIDTH-1:0]            load_value,
    output logic                        load_ack,
    output logic                        load_err,
    output logic                        tick_lost,
    output logic [NUM_STAGES*WIDTH-1:0] count,
    output logic                        carry_out,
    output logic [NUM_STAGES-1:0]       stage_sq
);

    logic [WIDTH-1:0]    maxArr [NUM_STAGES];
    logic [NUM_STAGES-1:0] atTerm;
    logic [NUM_STAGES:0]   chain;
    logic                  valueOk;
    logic                  accept;
    logic                  reject;
    logic                  doTick;

    always_comb begin
        valueOk = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (load_stage == stage_idx_t'(i))
                valueOk = (load_value <= maxArr[i]);
        end
    end

    assign accept = load_valid & ~clr & valueOk;
    assign reject = load_valid & ~clr & ~valueOk;
    assign doTick = tick_en & ~clr & ~accept;

    // chain[i]: every stage below i sits at its terminal value.
    assign chain[0] = 1'b1;

    for (genvar g = 0; g < NUM_STAGES; g++) begin : gStage
        // A modulus of 2^WIDTH reads as 0 here; minus one still gives all-ones.
        localparam logic [WIDTH-1:0] MAXV =
            WIDTH'(mod_of(MOD_BITS'(MODULI), WIDTH, g)) - WIDTH'(1);

        assign maxArr[g]  = MAXV;
        assign chain[g+1] = chain[g] & atTerm[g];

        mod_stage_counter #(
            .WIDTH(WIDTH),
            .MAX_V(MAXV)
        ) uStage (
            .clk       (clk),
            .nReset    (nReset),
            .clr       (clr),
            .load      (accept && load_stage == stage_idx_t'(g)),
            .load_value(load_value),
            .step      (doTick & chain[g]),
            .up_down   (up_down),
            .value     (count[g*WIDTH +: WIDTH]),
            .at_term   (atTerm[g]),
            .sq        (stage_sq[g])
        );
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            carry_out <= 1'b0;
            load_ack  <= 1'b0;
            load_err  <= 1'b0;
            tick_lost <= 1'b0;
        end else begin
            carry_out <= doTick & chain[NUM_STAGES];
            load_ack  <= accept;
            load_err  <= reject;
            tick_lost <= tick_en & (clr | accept);
        end
    end

endmodule
